// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Instruction-fetch controller. Owns the PC, issues four byte
//             reads per instruction, packs them big-endian into a 32-bit word
//             and presents it to decode over valid/ready. Redirects abort
//             any fetch in flight.
//  Options  : FETCH_ALIGN_CHECK_EN - a redirect to a target that is not
//             4-byte aligned locks the block in a sticky error state.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en,
   output logic              imem_rd,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [7:0]        imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr_word,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              fetch_err
);

   localparam logic [ADDR_W-1:0] STEP4 = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] STEP8 = ADDR_W'(8);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      LAST  = 2'd1,
      VALID = 2'd2,
      ERR   = 2'd3
   } state_t;

   state_t            state;
   logic [1:0]        cnt;        // index of the byte currently on the bus
   logic [ADDR_W-1:0] pc;
   logic [31:0]       word;
   logic              bad_target;

`ifdef FETCH_ALIGN_CHECK_EN
   assign bad_target = (redirect_target[1:0] != 2'b00);
`else
   assign bad_target = 1'b0;
`endif

   // The PC doubles as the address of the word being assembled or presented.
   assign instr_pc   = pc;
   assign instr_word = word;

   // Fetch sequencing: the read strobe and address are registered, so the
   // decision to start a fetch is taken on the edge that enters the first
   // read cycle (idle wake-up, handshake, or redirect).  The byte that
   // arrives during the first read cycle of a fetch is never captured,
   // which is what drops a stale byte after a redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FETCH;
         cnt         <= 2'd0;
         pc          <= RESET_PC;
         pc_plus4    <= RESET_PC + STEP4;
         word        <= 32'd0;
         imem_rd     <= 1'b0;
         imem_addr   <= '0;
         instr_valid <= 1'b0;
         fetch_err   <= 1'b0;
      end else if (state == ERR) begin
         // sticky until reset: no reads, no instructions, redirects ignored
         imem_rd     <= 1'b0;
         imem_addr   <= '0;
         instr_valid <= 1'b0;
      end else if (redirect_valid) begin
         cnt         <= 2'd0;
         instr_valid <= 1'b0;
         if (bad_target) begin
            state     <= ERR;
            fetch_err <= 1'b1;
            imem_rd   <= 1'b0;
            imem_addr <= '0;
         end else begin
            state     <= FETCH;
            pc        <= redirect_target;
            pc_plus4  <= redirect_target + STEP4;
            imem_rd   <= fetch_en;
            imem_addr <= fetch_en ? redirect_target : '0;
         end
      end else begin
         case (state)
            FETCH: begin
               if (!imem_rd) begin
                  // idle at the start of a fetch, waiting for permission
                  if (fetch_en) begin
                     imem_rd   <= 1'b1;
                     imem_addr <= pc;
                  end
               end else begin
                  case (cnt)
                     2'd1:    word[31:24] <= imem_rdata;
                     2'd2:    word[23:16] <= imem_rdata;
                     2'd3:    word[15:8]  <= imem_rdata;
                     default: ;
                  endcase
                  if (cnt == 2'd3) begin
                     state     <= LAST;
                     cnt       <= 2'd0;
                     imem_rd   <= 1'b0;
                     imem_addr <= '0;
                  end else begin
                     cnt       <= cnt + 2'd1;
                     imem_addr <= pc + ADDR_W'(cnt) + ADDR_W'(1);
                  end
               end
            end
            LAST: begin
               word[7:0]   <= imem_rdata;
               instr_valid <= 1'b1;
               state       <= VALID;
            end
            VALID: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  state       <= FETCH;
                  cnt         <= 2'd0;
                  pc          <= pc + STEP4;
                  pc_plus4    <= pc + STEP8;
                  imem_rd     <= fetch_en;
                  imem_addr   <= fetch_en ? (pc + STEP4) : '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
